icache_refill: RTL
==================

// Module: icache_refill
// PURPOSE
//  I-cache line refill engine, directly upstream of the I-cache data RAM. On a miss it issues
//  one incrementing read burst for the whole line, collects 32-bit beats, forwards the missed
//  word early, assembles the line, then writes data RAM, tag and valid in a single cycle.
//  It sits between the I-cache hit/miss logic and the instruction-side memory bus.
// PARAMETERS
//  DATA_WIDTH   32                      width of one memory beat / instruction word
//  OFFSET_SIZE  2**(`ICACHE_B-2)        words per cache line (beats per burst)
//  ADDR_WIDTH   32                      physical address width
//  TAG_WIDTH    ADDR_WIDTH-`ICACHE_S-`ICACHE_B   tag bits written to tag array
// PORTS
//  clk          in   1                    single clock, all state on posedge
//  reset        in   1                    synchronous, active-low (0 = reset)
//  miss_req     in   1                    miss pending; sampled only in IDLE
//  miss_addr    in   ADDR_WIDTH           missing fetch address; captured with miss_req
//  busy         out  1                    refill in progress (any state but IDLE)
//  refill_done  out  1                    1-cycle pulse: line, tag, valid written this cycle
//  crit_word    out  DATA_WIDTH           missed instruction word (early restart)
//  crit_valid   out  1                    1-cycle pulse when crit_word is valid
//  mem_arvalid  out  1                    burst read request valid
//  mem_araddr   out  ADDR_WIDTH           line-aligned burst base address
//  mem_arlen    out  8                    OFFSET_SIZE-1 (constant)
//  mem_arready  in   1                    request accepted
//  mem_rdata    in   DATA_WIDTH           read beat data
//  mem_rvalid   in   1                    read beat valid
//  mem_rlast    in   1                    last beat of burst
//  mem_rready   out  1                    beat accept (high only in RECV)
//  ram_addr     out  `ICACHE_S            set index to data RAM
//  ram_din      out  OFFSET_SIZE*32       assembled line, word i at bits [32i+31:32i]
//  ram_wen      out  1                    data RAM write enable
//  tag_din      out  TAG_WIDTH            tag of refilled line
//  tag_wen      out  1                    tag + valid write enable (valid written as 1)
//  burst_err    out  1                    sticky: rlast disagreed with beat count
// BEHAVIOUR
//  Reset (reset==0 at posedge): state IDLE, beat counter 0, line buffer 0, burst_err 0; all
//   outputs 0 except mem_arlen (constant). Reset mid-burst abandons refill, no RAM/tag write;
//   bus is reset by same signal.
//  FSM: IDLE -> REQ on miss_req (latch miss_addr). REQ: mem_arvalid=1, address held stable
//   until mem_arready; -> RECV. RECV: mem_rready=1; each rvalid beat stored to word[cnt],
//   cnt++ (log2(OFFSET_SIZE) bits). On beat OFFSET_SIZE-1 accepted -> WRITE.
//   WRITE: ram_wen=tag_wen=refill_done=1 for exactly one cycle -> IDLE.
//  Latency, zero-wait bus: miss_req cycle N, arvalid N+1, beats from N+2, WRITE 1 cycle after
//   last beat; next miss_req accepted the cycle after WRITE.
//  mem_araddr = {miss_addr[ADDR_WIDTH-1:`ICACHE_B], `ICACHE_B'b0}; ram_addr =
//   miss_addr[`ICACHE_S+`ICACHE_B-1:`ICACHE_B]; tag_din = miss_addr[ADDR_WIDTH-1:`ICACHE_S+`ICACHE_B].
//  crit_valid pulses on the accepted beat whose index == miss_addr[`ICACHE_B-1:2];
//   crit_word = mem_rdata that same cycle (combinational pass-through, no extra latency).
//  rlast: expected exactly on beat OFFSET_SIZE-1. rlast early -> burst_err=1, remaining words
//   stay 0, go to WRITE. rlast missing on final beat -> burst_err=1, proceed to WRITE anyway.
//  miss_req outside IDLE ignored; miss_addr changes after capture have no effect.
//  rvalid outside RECV ignored (rready=0). ram_din/tag_din/ram_addr stable through WRITE.
// STRUCTURE
//  Shared pkg/header iCache.vh: `ICACHE_S, `ICACHE_B, TAG_WIDTH derivation, refill state enum
//   {IDLE, REQ, RECV, WRITE}. No sub-module: FSM, counter and line buffer in one module; data
//   RAM and tag array instantiated by the I-cache top, not here.
// TESTING  (`ICACHE_S=7, `ICACHE_B=5, OFFSET_SIZE=8)
//  1 miss 0x1FC0_1234, zero-wait, beats 0xA0..0xA7 -> araddr 0x1FC0_1220, arlen 7, ram_addr
//    0x11, tag_din 0x1FC01, ram_din word i = 0xA0+i, ram_wen/tag_wen/refill_done 1 cycle.
//  2 same miss -> crit_valid on 6th beat (index 5), crit_word 0xA5, single pulse.
//  3 arready delayed 3 cycles, rvalid toggled every other cycle -> araddr stable, line
//    identical to test 1, burst_err 0.
//  4 rlast on beat 3 -> burst_err 1, WRITE next cycle, words 4..7 = 0.
//  5 reset low during beat 4, then miss 0x0000_0040 -> no write for first miss; second refill
//    ram_addr 0x02, tag 0, correct line.
//  6 miss_req held high during RECV with other address -> ignored; refill follows first addr.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared I-cache geometry and refill FSM state encoding
package icache_refill_pkg;

  localparam int ICACHE_S         = 7;
  localparam int ICACHE_B         = 5;
  localparam int ICACHE_WORD_BITS = 32;
  localparam int ICACHE_ADDR_BITS = 32;
  localparam int ICACHE_LINE_WORDS = 2 ** (ICACHE_B - 2);
  localparam int ICACHE_TAG_BITS  = ICACHE_ADDR_BITS - ICACHE_S - ICACHE_B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - I-cache line refill engine: one burst per miss, early restart, single-cycle line write
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int DATA_WIDTH  = ICACHE_WORD_BITS,
  parameter int ADDR_WIDTH  = ICACHE_ADDR_BITS,
  parameter int OFFSET_SIZE = ICACHE_LINE_WORDS,
  parameter int TAG_WIDTH   = ADDR_WIDTH - ICACHE_S - ICACHE_B
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              miss_req,
  input  logic [ADDR_WIDTH-1:0]             miss_addr,
  output logic                              busy,
  output logic                              refill_done,
  output logic [DATA_WIDTH-1:0]             crit_word,
  output logic                              crit_valid,
  output logic                              mem_arvalid,
  output logic [ADDR_WIDTH-1:0]             mem_araddr,
  output logic [7:0]                        mem_arlen,
  input  logic                              mem_arready,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_rvalid,
  input  logic                              mem_rlast,
  output logic                              mem_rready,
  output logic [ICACHE_S-1:0]               ram_addr,
  output logic [OFFSET_SIZE*DATA_WIDTH-1:0] ram_din,
  output logic                              ram_wen,
  output logic [TAG_WIDTH-1:0]              tag_din,
  output logic                              tag_wen,
  output logic                              burst_err
);

  localparam int CNT_WIDTH = $clog2(OFFSET_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(OFFSET_SIZE - 1);

  refill_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  word_q [OFFSET_SIZE];
  logic                   err_q;

  logic                   capture;
  logic                   beat_accept;
  logic                   final_beat;
  logic                   unused_addr_bits;

  assign capture     = (state_q == IDLE) && miss_req;
  assign beat_accept = (state_q == RECV) && mem_rvalid;
  assign final_beat  = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_req) state_d = REQ;
      REQ:     if (mem_arready) state_d = RECV;
      // An early rlast ends the burst; the unfilled words keep their cleared value.
      RECV:    if (mem_rvalid && (final_beat || mem_rlast)) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < OFFSET_SIZE; i++) word_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q <= miss_addr;
        cnt_q  <= '0;
        for (int i = 0; i < OFFSET_SIZE; i++) word_q[i] <= '0;
      end
      if (beat_accept) begin
        word_q[cnt_q] <= mem_rdata;
        cnt_q         <= cnt_q + CNT_WIDTH'(1);
        if (mem_rlast != final_beat) err_q <= 1'b1;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign mem_arvalid = (state_q == REQ);
  assign mem_rready  = (state_q == RECV);
  assign ram_wen     = (state_q == WRITE);
  assign tag_wen     = (state_q == WRITE);
  assign refill_done = (state_q == WRITE);
  assign burst_err   = err_q;
  assign mem_arlen   = 8'(OFFSET_SIZE - 1);

  assign mem_araddr = {addr_q[ADDR_WIDTH-1:ICACHE_B], {ICACHE_B{1'b0}}};
  assign ram_addr   = addr_q[ICACHE_S+ICACHE_B-1:ICACHE_B];
  assign tag_din    = addr_q[ADDR_WIDTH-1:ICACHE_S+ICACHE_B];

  // Early restart: the missed word leaves on the same cycle it arrives from the bus.
  assign crit_valid = beat_accept && (cnt_q == addr_q[ICACHE_B-1:2]);
  assign crit_word  = crit_valid ? mem_rdata : '0;

  for (genvar g = 0; g < OFFSET_SIZE; g++) begin : g_pack
    assign ram_din[g*DATA_WIDTH +: DATA_WIDTH] = word_q[g];
  end

  assign unused_addr_bits = ^addr_q[1:0];

endmodule
